// File: rtl/mul8_eval_pkg.sv
// Shared definitions for the 8x8 multiplier evaluation blocks.
//   OP_W / PROD_W       : operand and product widths of the multiplier under test
//   CNT_W_DEF / SUM_W_DEF: default counter and error-accumulator widths
//   state_t             : control states of the error monitor
package mul8_eval_pkg;

    localparam int unsigned OP_W      = 8;
    localparam int unsigned PROD_W    = 16;
    localparam int unsigned CNT_W_DEF = 17;
    localparam int unsigned SUM_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mul8_exact.sv
// Combinational exact 8x8 unsigned multiplier; golden reference for
// approximate-multiplier evaluation.
//   a, b : OP_W-bit unsigned operands
//   p    : PROD_W-bit exact product a*b
module mul8_exact
    import mul8_eval_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] p
);

    assign p = PROD_W'(a) * PROD_W'(b);

endmodule

// File: rtl/mul8_err_monitor.sv
// Streaming error-metrics accumulator for an 8x8 approximate multiplier.
// Accumulates absolute-error sum (saturating), worst-case error, error count
// and sample count over a run of num_samples beats.
//   clk, rst            : clock, synchronous active-high reset
//   start, num_samples  : run launch (honoured only when idle) and run length
//   in_valid/in_ready   : beat handshake; ready only while running
//   in_a, in_b, in_p    : operands and approximate product
//   busy, done          : run in progress / one-cycle completion pulse
//   err_sum, err_max, err_cnt, smp_cnt : accumulated results
module mul8_err_monitor
    import mul8_eval_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned SUM_W = SUM_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_samples,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    input  logic [PROD_W-1:0] in_p,
    output logic              busy,
    output logic              done,
    output logic [SUM_W-1:0]  err_sum,
    output logic [PROD_W-1:0] err_max,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  smp_cnt
);

    // Wide enough to hold err_sum + d without losing the carry for any SUM_W.
    localparam int unsigned ACC_W = ((SUM_W > PROD_W) ? SUM_W : PROD_W) + 1;

    state_t             state, state_next;
    logic [CNT_W-1:0]   remaining;
    logic               accept;
    logic               start_ok;

    logic [PROD_W-1:0]  exact;
    logic               s1_valid;
    logic [PROD_W-1:0]  s1_exact;
    logic [PROD_W-1:0]  s1_p;

    logic [PROD_W-1:0]  d;
    logic [ACC_W-1:0]   sum_wide;
    logic [SUM_W-1:0]   sum_next;

    assign start_ok = (state == ST_IDLE) && start;
    assign accept   = in_valid && in_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // ---------------- FSM: next state ----------------
    // A zero-length run still passes through DRAIN so done appears two
    // cycles after start, with the (empty) pipeline trivially retired.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (start) state_next = (num_samples == '0) ? ST_DRAIN : ST_RUN;
            ST_RUN:   if (accept && remaining == CNT_W'(1)) state_next = ST_DRAIN;
            ST_DRAIN: state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready = (state == ST_RUN);
        busy     = (state != ST_IDLE);
        done     = (state == ST_DONE);
    end

    // ---------------- remaining-beat counter ----------------
    always_ff @(posedge clk) begin
        if (rst)           remaining <= '0;
        else if (start_ok) remaining <= num_samples;
        else if (accept)   remaining <= remaining - CNT_W'(1);
    end

    // ---------------- S1: exact product ----------------
    mul8_exact u_exact (
        .a (in_a),
        .b (in_b),
        .p (exact)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_exact <= '0;
            s1_p     <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_exact <= exact;
                s1_p     <= in_p;
            end
        end
    end

    // ---------------- S2: error and accumulation ----------------
    always_comb begin
        d        = (s1_exact >= s1_p) ? (s1_exact - s1_p) : (s1_p - s1_exact);
        sum_wide = ACC_W'(err_sum) + ACC_W'(d);
        sum_next = (sum_wide > ACC_W'({SUM_W{1'b1}})) ? '1 : sum_wide[SUM_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            err_sum <= '0;
            err_max <= '0;
            err_cnt <= '0;
            smp_cnt <= '0;
        end else if (s1_valid) begin
            err_sum <= sum_next;
            if (d > err_max) err_max <= d;
            if (d != '0)     err_cnt <= err_cnt + CNT_W'(1);
            smp_cnt <= smp_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mul8_err_monitor.sv
module tb_mul8_err_monitor;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // main instance, default widths
    logic        start, in_valid, in_ready, busy, done;
    logic [16:0] num_samples, err_cnt, smp_cnt;
    logic [7:0]  in_a, in_b;
    logic [15:0] in_p, err_max;
    logic [31:0] err_sum;

    // narrow-accumulator instance for saturation
    logic        s_start, s_in_valid, s_in_ready, s_busy, s_done;
    logic [16:0] s_num_samples, s_err_cnt, s_smp_cnt;
    logic [7:0]  s_in_a, s_in_b;
    logic [15:0] s_in_p, s_err_max;
    logic [7:0]  s_err_sum;

    mul8_err_monitor u_dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_p(in_p), .busy(busy), .done(done), .err_sum(err_sum),
        .err_max(err_max), .err_cnt(err_cnt), .smp_cnt(smp_cnt)
    );

    mul8_err_monitor #(.CNT_W(17), .SUM_W(8)) u_sat (
        .clk(clk), .rst(rst), .start(s_start), .num_samples(s_num_samples),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_a(s_in_a), .in_b(s_in_b),
        .in_p(s_in_p), .busy(s_busy), .done(s_done), .err_sum(s_err_sum),
        .err_max(s_err_max), .err_cnt(s_err_cnt), .smp_cnt(s_smp_cnt)
    );

    int unsigned tests = 0;
    int unsigned fails = 0;

    logic [7:0]  qa[$];
    logic [7:0]  qb[$];
    logic [15:0] qp[$];

    // Reference: error metrics straight from the definition over the beat list.
    longint m_sum;
    longint m_max;
    longint m_cnt;
    task automatic model(input int sumw);
        longint e, cap;
        cap   = (longint'(1) << sumw) - 1;
        m_sum = 0; m_max = 0; m_cnt = 0;
        foreach (qa[i]) begin
            e = longint'(qa[i]) * longint'(qb[i]) - longint'(qp[i]);
            if (e < 0) e = -e;
            m_sum += e;
            if (e > m_max) m_max = e;
            if (e != 0) m_cnt++;
        end
        if (m_sum > cap) m_sum = cap;
    endtask

    task automatic clear_q();
        qa.delete(); qb.delete(); qp.delete();
    endtask

    task automatic add_beat(input int a, input int b, input int p);
        qa.push_back(8'(a)); qb.push_back(8'(b)); qp.push_back(16'(p));
    endtask

    // Runs the queued beats through u_dut (entered and left at a negedge, idle)
    // and checks handshake timing, done latency and final results.
    task automatic run_main(input string tag, input bit gaps, input bit pokes);
        int n, idx, budget, k;
        bit acc, ready_bad;
        n = qa.size();
        model(32);
        tests++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s idle_flags: in_ready=%b busy=%b, required 0 0", tag, in_ready, busy);
        end
        start = 1'b1; num_samples = 17'(n);
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (busy !== 1'b1 || in_ready !== (n != 0)) begin
            fails++;
            $display("FAIL %s after_start: busy=%b in_ready=%b, required 1 %b", tag, busy, in_ready, n != 0);
        end
        idx = 0; budget = 0; ready_bad = 0;
        while (idx < n && budget < 4 * n + 100) begin
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (in_valid) begin
                in_a = qa[idx]; in_b = qb[idx]; in_p = qp[idx];
            end else begin
                in_a = 8'($urandom); in_b = 8'($urandom); in_p = 16'($urandom);
            end
            if (pokes) begin
                start = 1'($urandom); num_samples = 17'($urandom_range(0, 5));
            end
            if (in_ready !== 1'b1) ready_bad = 1;
            acc = in_valid && in_ready;
            @(negedge clk);
            if (acc) idx++;
            budget++;
        end
        in_valid = 1'b0; start = 1'b0; num_samples = '0;
        tests++;
        if (idx != n || ready_bad) begin
            fails++;
            $display("FAIL %s beat_feed: accepted=%0d ready_drop=%0d, required %0d 0", tag, idx, ready_bad, n);
        end
        // now one cycle past the last accepting edge (or past the start edge for n==0)
        k = 1;
        while (done !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (k != 2) begin
            fails++;
            $display("FAIL %s done_latency: %0d cycles, required 2", tag, k);
        end
        tests++;
        if (err_sum !== 32'(m_sum) || err_max !== 16'(m_max) ||
            err_cnt !== 17'(m_cnt) || smp_cnt !== 17'(n)) begin
            fails++;
            $display("FAIL %s results: sum=%0d max=%0d cnt=%0d smp=%0d, required %0d %0d %0d %0d",
                     tag, err_sum, err_max, err_cnt, smp_cnt, m_sum, m_max, m_cnt, n);
        end
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL %s ready_in_done: in_ready=%b, required 0", tag, in_ready);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || err_sum !== 32'(m_sum) || smp_cnt !== 17'(n)) begin
            fails++;
            $display("FAIL %s after_done: done=%b busy=%b sum=%0d smp=%0d, required 0 0 %0d %0d",
                     tag, done, busy, err_sum, smp_cnt, m_sum, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        tests++;
        if (in_ready !== 0 || busy !== 0 || done !== 0 || err_sum !== 0 ||
            err_max !== 0 || err_cnt !== 0 || smp_cnt !== 0) begin
            fails++;
            $display("FAIL reset_values: rdy=%b busy=%b done=%b sum=%0d max=%0d cnt=%0d smp=%0d, required all 0",
                     in_ready, busy, done, err_sum, err_max, err_cnt, smp_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_exact_stream();
        clear_q();
        add_beat(3, 5, 15); add_beat(255, 255, 65025); add_beat(0, 7, 0); add_beat(128, 2, 256);
        run_main("exact_stream", 0, 0);
    endtask

    task automatic test_single_error();
        clear_q();
        add_beat(255, 255, 64729);
        run_main("single_error", 0, 0);
    endtask

    task automatic test_zero_samples();
        clear_q();
        run_main("zero_samples", 0, 0);
    endtask

    task automatic test_handshake();
        clear_q();
        for (int i = 0; i < 24; i++) begin
            int a, b;
            a = $urandom_range(0, 255); b = $urandom_range(0, 255);
            if (i % 3 == 0) add_beat(a, b, a * b);
            else            add_beat(a, b, $urandom_range(0, 65535));
        end
        run_main("handshake_gaps", 1, 1);
        run_main("handshake_nogap", 0, 0);
    endtask

    task automatic test_reset_mid_run();
        int fed;
        clear_q();
        for (int i = 0; i < 10; i++) add_beat($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 65535));
        start = 1'b1; num_samples = 17'd10;
        @(negedge clk);
        start = 1'b0;
        fed = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = qa[i]; in_b = qb[i]; in_p = qp[i];
            if (in_ready === 1'b1) fed++;
            @(negedge clk);
        end
        in_valid = 1'b1; in_a = 8'd255; in_b = 8'd255; in_p = 16'd0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        tests++;
        if (fed != 3 || in_ready !== 0 || busy !== 0 || done !== 0 || err_sum !== 0 ||
            err_max !== 0 || err_cnt !== 0 || smp_cnt !== 0) begin
            fails++;
            $display("FAIL mid_run_reset: fed=%0d rdy=%b busy=%b done=%b sum=%0d max=%0d cnt=%0d smp=%0d, required 3 and all 0",
                     fed, in_ready, busy, done, err_sum, err_max, err_cnt, smp_cnt);
        end
        @(negedge clk); @(negedge clk);
        tests++;
        if (busy !== 0 || err_sum !== 0 || smp_cnt !== 0) begin
            fails++;
            $display("FAIL post_reset_idle: busy=%b sum=%0d smp=%0d, required 0 0 0", busy, err_sum, smp_cnt);
        end
        clear_q();
        for (int i = 0; i < 6; i++) add_beat($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 65535));
        run_main("fresh_after_reset", 0, 0);
    endtask

    task automatic test_exhaustive();
        clear_q();
        for (int a = 0; a < 256; a++)
            for (int b = 0; b < 256; b++)
                add_beat(a, b, a * b + 1);
        run_main("exhaustive", 0, 0);
    endtask

    task automatic test_saturation();
        for (int r = 0; r < 2; r++) begin
            int k;
            clear_q();
            if (r == 0) begin add_beat(0, 0, 200); add_beat(0, 0, 200); end
            else        begin add_beat(10, 10, 0); add_beat(0, 0, 250); end
            model(8);
            s_start = 1'b1; s_num_samples = 17'd2;
            @(negedge clk);
            s_start = 1'b0;
            foreach (qa[i]) begin
                s_in_valid = 1'b1; s_in_a = qa[i]; s_in_b = qb[i]; s_in_p = qp[i];
                @(negedge clk);
            end
            s_in_valid = 1'b0;
            k = 1;
            while (s_done !== 1'b1 && k < 10) begin
                @(negedge clk);
                k++;
            end
            tests++;
            if (k != 2 || s_err_sum !== 8'(m_sum) || s_err_max !== 16'(m_max) ||
                s_err_cnt !== 17'(m_cnt) || s_smp_cnt !== 17'd2) begin
                fails++;
                $display("FAIL saturation_%0d: lat=%0d sum=%0d max=%0d cnt=%0d smp=%0d, required 2 %0d %0d %0d 2",
                         r, k, s_err_sum, s_err_max, s_err_cnt, s_smp_cnt, m_sum, m_max, m_cnt);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 0; num_samples = '0; in_valid = 0; in_a = '0; in_b = '0; in_p = '0;
        s_start = 0; s_num_samples = '0; s_in_valid = 0; s_in_a = '0; s_in_b = '0; s_in_p = '0;
        test_reset();
        test_exact_stream();
        test_single_error();
        test_zero_samples();
        test_handshake();
        test_saturation();
        test_reset_mid_run();
        test_exhaustive();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
